uart_rx_frame: RTL



---
 rtl/uart_pkg.sv | 27 ++
 rtl/sync2.sv | 34 +++
 rtl/uart_rx_frame.sv | 124 ++++++++++++
 3 files changed

// File: rtl/uart_pkg.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module      : uart_pkg
// Description : Shared types and constants for the UART receive path: the
//               framing FSM state type, default frame width and the bit
//               period constants used by the mid-bit sample generator.
// Revision    : 1.0 - initial release
// ============================================================================
package uart_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        START = 2'd1,
        DATA  = 2'd2,
        STOP  = 2'd3
    } rx_state_e;

    localparam int DATA_BITS_DEFAULT = 8;

    // Bit period in sysclk cycles and the count at which the mid-bit
    // strobe fires.
    localparam int BIT_CYCLES = 5208;
    localparam int MID_BIT    = 2603;

endpackage : uart_pkg
`default_nettype wire

// File: rtl/sync2.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module      : sync2
// Description : Two-flop synchronizer for a single asynchronous input. Both
//               flops reset to 1 so an idle-high serial line does not look
//               like a falling edge when reset is released.
// Ports       : clk  - destination clock
//               rst  - asynchronous active-high reset
//               i_d  - asynchronous input
//               o_q  - synchronized output (two clk cycles of latency)
// Revision    : 1.0 - initial release
// ============================================================================
module sync2 (
    input  logic clk,
    input  logic rst,
    input  logic i_d,
    output logic o_q
);

    logic [1:0] r_sync;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_sync <= 2'b11;
        end else begin
            r_sync <= {r_sync[0], i_d};
        end
    end

    assign o_q = r_sync[1];

endmodule : sync2
`default_nettype wire

// File: rtl/uart_rx_frame.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module      : uart_rx_frame
// Description : Byte-framing receiver for an asynchronous serial line.
//               Detects the start-bit falling edge, enables an external
//               mid-bit sample generator, and uses its strobes to capture
//               the start, data (LSB first) and stop bits. A good frame
//               updates data with a one-cycle valid pulse; a low stop bit
//               gives a one-cycle frame_err pulse and leaves data unchanged.
// Ports       : sysclk       - system clock, rising edge
//               reset        - asynchronous active-high reset
//               rx           - raw serial line, idle high, asynchronous
//               sample_pulse - one-cycle mid-bit strobe from the generator
//               sample_en    - generator enable; low clears its counter
//               data         - last good received byte
//               valid        - one-cycle pulse when data is updated
//               frame_err    - one-cycle pulse on a low stop bit
// Revision    : 1.0 - initial release
// ============================================================================
module uart_rx_frame
    import uart_pkg::*;
#(
    parameter int DATA_BITS = DATA_BITS_DEFAULT
) (
    input  logic                 sysclk,
    input  logic                 reset,
    input  logic                 rx,
    input  logic                 sample_pulse,
    output logic                 sample_en,
    output logic [DATA_BITS-1:0] data,
    output logic                 valid,
    output logic                 frame_err
);

    localparam int                   c_cnt_w    = $clog2(DATA_BITS + 1);
    localparam logic [c_cnt_w-1:0]   c_last_bit = c_cnt_w'(DATA_BITS - 1);

    logic                 w_rx_s;
    logic                 r_rx_d;
    rx_state_e            r_state;
    logic [c_cnt_w-1:0]   r_bit_cnt;
    logic [DATA_BITS-1:0] r_shift;

    sync2 u_sync_rx (
        .clk (sysclk),
        .rst (reset),
        .i_d (rx),
        .o_q (w_rx_s)
    );

    always_ff @(posedge sysclk or posedge reset) begin
        if (reset) begin
            r_rx_d    <= 1'b1;
            r_state   <= IDLE;
            r_bit_cnt <= '0;
            r_shift   <= '0;
            sample_en <= 1'b0;
            data      <= '0;
            valid     <= 1'b0;
            frame_err <= 1'b0;
        end else begin
            r_rx_d    <= w_rx_s;
            valid     <= 1'b0;
            frame_err <= 1'b0;

            case (r_state)
                IDLE: begin
                    // Only a genuine 1->0 transition arms the receiver; a
                    // line that is stuck low is ignored.
                    if (r_rx_d && !w_rx_s) begin
                        r_state   <= START;
                        sample_en <= 1'b1;
                    end
                end

                START: begin
                    if (sample_pulse) begin
                        if (!w_rx_s) begin
                            r_state   <= DATA;
                            r_bit_cnt <= '0;
                        end else begin
                            // Line back high at mid start bit: glitch.
                            r_state   <= IDLE;
                            sample_en <= 1'b0;
                        end
                    end
                end

                DATA: begin
                    if (sample_pulse) begin
                        // New bit enters at the MSB so the LSB-first byte
                        // ends up right-aligned after DATA_BITS strobes.
                        r_shift   <= {w_rx_s, r_shift[DATA_BITS-1:1]};
                        r_bit_cnt <= r_bit_cnt + 1'b1;
                        if (r_bit_cnt == c_last_bit) begin
                            r_state <= STOP;
                        end
                    end
                end

                STOP: begin
                    if (sample_pulse) begin
                        r_state   <= IDLE;
                        sample_en <= 1'b0;
                        if (w_rx_s) begin
                            data  <= r_shift;
                            valid <= 1'b1;
                        end else begin
                            frame_err <= 1'b1;
                        end
                    end
                end

                default: begin
                    r_state   <= IDLE;
                    sample_en <= 1'b0;
                end
            endcase
        end
    end

endmodule : uart_rx_frame
`default_nettype wire
